// File: rtl/button_event_if.sv
// Event channel from the button arbiter to the downstream control FSM.
// The master offers evt_idx/evt_rel under evt_valid; the slave accepts with evt_ready.
interface button_event_if #(
    parameter int IDX_W = 3
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_rel;

    modport master (
        output evt_valid,
        output evt_idx,
        output evt_rel,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        input  evt_rel,
        output evt_ready
    );
endinterface

// File: rtl/button_event_arbiter.sv
// Turns debounced button edges into queued one-shot events, served round-robin over one channel.
// Optional macro RELEASE_EVENT_EN adds release events on falling edges.
//
// state | meaning
// IDLE  | no event offered; pick the next pending source at or after rr_ptr
// OFFER | event held on evt_idx/evt_rel until evt_ready
module button_event_arbiter #(
    parameter int N_BTN = 5,
    parameter int IDX_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_BTN-1:0]   btn_in,
    button_event_if.master     evt,
    output logic [N_BTN-1:0]   ovf,
    input  logic               ovf_clr,
    output logic               state_out
);
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [N_BTN-1:0]   prev, rise, press_pend, press_clr, press_ovf, drop;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt, idx_q, idx_nxt, sel_idx;
    logic               valid_q, valid_nxt, rel_q, rel_nxt, sel_rel, found, accept;

    assign rise   = btn_in & ~prev;
    assign accept = (state == OFFER) && evt.evt_ready;

    always_comb begin
        press_clr = '0;
        for (int i = 0; i < N_BTN; i++)
            press_clr[i] = accept && !rel_q && (idx_q == IDX_W'(i));
    end

    // A rise on a source that is still pending and not being served right now is lost.
    assign press_ovf = rise & press_pend & ~press_clr;

`ifdef RELEASE_EVENT_EN
    logic [N_BTN-1:0] fall, rel_pend, rel_clr, rel_ovf;

    assign fall = ~btn_in & prev;

    always_comb begin
        rel_clr = '0;
        for (int i = 0; i < N_BTN; i++)
            rel_clr[i] = accept && rel_q && (idx_q == IDX_W'(i));
    end

    assign rel_ovf = fall & rel_pend & ~rel_clr;
    assign drop    = press_ovf | rel_ovf;

    always_ff @(posedge clk) begin
        if (reset) rel_pend <= '0;
        else       rel_pend <= (rel_pend & ~rel_clr) | fall;
    end

    assign evt.evt_rel = rel_q;
`else
    assign drop        = press_ovf;
    assign evt.evt_rel = 1'b0;
`endif

    // Search order starts at rr_ptr; within one index press precedes release.
    always_comb begin
        int j;
        j       = 0;
        found   = 1'b0;
        sel_idx = '0;
        sel_rel = 1'b0;
        for (int k = 0; k < N_BTN; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N_BTN) j = j - N_BTN;
            if (!found && press_pend[j]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(j);
                sel_rel = 1'b0;
            end
`ifdef RELEASE_EVENT_EN
            else if (!found && rel_pend[j]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(j);
                sel_rel = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        idx_nxt   = idx_q;
        rel_nxt   = rel_q;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OFFER;
                    valid_nxt = 1'b1;
                    idx_nxt   = sel_idx;
                    rel_nxt   = sel_rel;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    rr_nxt    = (idx_q == IDX_W'(N_BTN - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            rel_q      <= 1'b0;
            rr_ptr     <= '0;
            prev       <= '0;
            press_pend <= '0;
            ovf        <= '0;
        end else begin
            state      <= state_nxt;
            valid_q    <= valid_nxt;
            idx_q      <= idx_nxt;
            rel_q      <= rel_nxt;
            rr_ptr     <= rr_nxt;
            prev       <= btn_in;
            press_pend <= (press_pend & ~press_clr) | rise;
            ovf        <= (ovf & ~{N_BTN{ovf_clr}}) | drop;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_idx   = idx_q;
    assign state_out     = (state == OFFER);
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: expected events are queued as buttons are driven
// and compared at each handshake; also checks latency, ordering, stalls, overflow and reset.
module tb_button_event_arbiter;
    localparam int N_BTN = 5;
    localparam int IDX_W = 3;
`ifdef RELEASE_EVENT_EN
    localparam int T6_EVENTS = 2;
`else
    localparam int T6_EVENTS = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] ovf;
    logic             ovf_clr;
    logic             state_out;

    button_event_if #(.IDX_W(IDX_W)) bus();

    button_event_arbiter #(.N_BTN(N_BTN), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .evt       (bus),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [IDX_W:0] sb_q[$];
    int             hs_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input int idx, input logic rel);
        sb_q.push_back({rel, IDX_W'(idx)});
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        btn_in        = '0;
        bus.evt_ready = 1'b1;
        ovf_clr       = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) step();
        check_val(tag, sb_q.size(), 0);
    endtask

    // Handshake monitor: sampled on the falling edge, away from input changes and the active edge.
    initial begin
        logic           stall_seen;
        logic [IDX_W:0] stall_val;
        logic [IDX_W:0] exp_evt;
        stall_seen = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_seen = 1'b0;
            end else begin
                if (stall_seen)
                    check_val("stall_hold", {bus.evt_valid, bus.evt_rel, bus.evt_idx}, {1'b1, stall_val});
                if (bus.evt_valid && bus.evt_ready) begin
                    check_val("sb_nonempty", 32'(sb_q.size() != 0), 1);
                    if (sb_q.size() != 0) begin
                        exp_evt = sb_q.pop_front();
                        check_val("evt_idx", bus.evt_idx, exp_evt[IDX_W-1:0]);
                        check_val("evt_rel", bus.evt_rel, exp_evt[IDX_W]);
                    end
                    hs_cyc.push_back(cyc);
                end
                stall_seen = bus.evt_valid && !bus.evt_ready;
                stall_val  = {bus.evt_rel, bus.evt_idx};
            end
        end
    end

    initial begin
        reset         = 1'b1;
        btn_in        = '0;
        ovf_clr       = 1'b0;
        bus.evt_ready = 1'b1;
        do_reset();

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            step();
            check_val("t1_valid", bus.evt_valid, 0);
            check_val("t1_ovf", ovf, 0);
            check_val("t1_state", state_out, 0);
        end

        // 2: single press latency, one event while held
        hs_cyc.delete();
        push_evt(2, 1'b0);
        btn_in[2] = 1'b1;
        step();
        check_val("t2_valid_e1", bus.evt_valid, 0);
        step();
        check_val("t2_valid_e2", bus.evt_valid, 1);
        check_val("t2_idx_e2", bus.evt_idx, 2);
        check_val("t2_state_e2", state_out, 1);
        step();
        check_val("t2_valid_e3", bus.evt_valid, 0);
        repeat (10) step();
        check_val("t2_hs_count", hs_cyc.size(), 1);

        // 3: simultaneous presses served round-robin, then wrap to idx 0
        do_reset();
        hs_cyc.delete();
        push_evt(0, 1'b0);
        push_evt(1, 1'b0);
        push_evt(3, 1'b0);
        btn_in = 5'b01011;
        drain("t3_drain", 20);
        check_val("t3_hs_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check_val("t3_gap01", hs_cyc[1] - hs_cyc[0], 2);
            check_val("t3_gap13", hs_cyc[2] - hs_cyc[1], 2);
        end
        btn_in[0] = 1'b0;
        step();
`ifdef RELEASE_EVENT_EN
        push_evt(0, 1'b1);
        drain("t3_rel0", 20);
`endif
        push_evt(0, 1'b0);
        btn_in[0] = 1'b1;
        drain("t3_wrap", 20);

        // 4: stalled offer, overflow, ovf_clr precedence
        do_reset();
        bus.evt_ready = 1'b0;
        push_evt(4, 1'b0);
`ifdef RELEASE_EVENT_EN
        push_evt(4, 1'b1);
`endif
        btn_in[4] = 1'b1;
        step();
        step();
        check_val("t4_valid", bus.evt_valid, 1);
        check_val("t4_idx", bus.evt_idx, 4);
        btn_in[4] = 1'b0;
        step();
        btn_in[4] = 1'b1;
        step();
        check_val("t4_ovf_set", ovf, 5'b10000);
        btn_in[4] = 1'b0;
        step();
        btn_in[4] = 1'b1;
        ovf_clr   = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_val("t4_ovf_clr_vs_set", ovf, 5'b10000);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_val("t4_ovf_cleared", ovf, 0);
        check_val("t4_idx_still", bus.evt_idx, 4);
        bus.evt_ready = 1'b1;
        drain("t4_drain", 20);

        // 5: reset while offering idx 1 loses the event
        do_reset();
        bus.evt_ready = 1'b0;
        btn_in[1] = 1'b1;
        step();
        step();
        check_val("t5_valid", bus.evt_valid, 1);
        check_val("t5_idx", bus.evt_idx, 1);
        reset  = 1'b1;
        btn_in = '0;
        step();
        check_val("t5_valid_rst", bus.evt_valid, 0);
        check_val("t5_state_rst", state_out, 0);
        step();
        reset = 1'b0;
        bus.evt_ready = 1'b1;
        hs_cyc.delete();
        repeat (10) step();
        check_val("t5_no_event", hs_cyc.size(), 0);

        // 6: press then release
        do_reset();
        hs_cyc.delete();
        push_evt(1, 1'b0);
        btn_in[1] = 1'b1;
        repeat (4) step();
        btn_in[1] = 1'b0;
`ifdef RELEASE_EVENT_EN
        push_evt(1, 1'b1);
`endif
        drain("t6_drain", 20);
        repeat (10) step();
        check_val("t6_hs_count", hs_cyc.size(), T6_EVENTS);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
